tile_draw_scheduler: RTL and testbench

- Round-robin arbiter and sequencer sharing the single 4x4 tile drawer (LOADX/LOADY/draw-16 handshake controller) among NUM_REQ requesters, e.g. screen restore, sprite erase and sprite draw.
- Accepts one tile request at a time and drives the drawer's load-X/plot handshake.
- Waits for the drawer to return to idle, then reports completion to the owning requester.
- Watchdog flags a drawer that never completes.

---
 rtl/tile_draw_scheduler_if.sv | 31 +++
 rtl/tile_draw_scheduler.sv | 127 ++++++++++++
 tb/tb_tile_draw_scheduler.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_draw_scheduler_if.sv
// rtl/tile_draw_scheduler_if.sv - requester and drawer signal bundle for tile_draw_scheduler
interface tile_draw_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [9*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_color;
  logic [NUM_REQ-1:0]   req_grant;
  logic [NUM_REQ-1:0]   req_done;
  logic [8:0]           drw_data_x;
  logic [7:0]           drw_data_y;
  logic [2:0]           drw_color;
  logic                 drw_load_x;
  logic                 drw_plot;
  logic                 drw_done;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    input  req_valid, req_x, req_y, req_color, drw_done,
    output req_grant, req_done, drw_data_x, drw_data_y, drw_color,
           drw_load_x, drw_plot, busy, timeout_err
  );

  modport slave (
    output req_valid, req_x, req_y, req_color, drw_done,
    input  req_grant, req_done, drw_data_x, drw_data_y, drw_color,
           drw_load_x, drw_plot, busy, timeout_err
  );
endinterface

// File: rtl/tile_draw_scheduler.sv
// rtl/tile_draw_scheduler.sv - round-robin sharing of one 4x4 tile drawer among NUM_REQ requesters
module tile_draw_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  tile_draw_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE_X, ISSUE_Y, WAIT_DONE, FINISH} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [TO_W-1:0]  watchdog;
  logic             found;
  logic             grant_go;
  logic [8:0]       cap_x;
  logic [7:0]       cap_y;
  logic [2:0]       cap_color;

  // Search from ptr+1 upward with wrap; the last requester served has lowest priority.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_w;
    winner = ptr;
    found  = 1'b0;
    cand   = 0;
    cand_w = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_w = IDX_W'(cand);
      if (!found && bus.req_valid[cand_w]) begin
        found  = 1'b1;
        winner = cand_w;
      end
    end
  end

  always_comb begin
    cap_x     = '0;
    cap_y     = '0;
    cap_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        cap_x     = bus.req_x[9*i +: 9];
        cap_y     = bus.req_y[8*i +: 8];
        cap_color = bus.req_color[3*i +: 3];
      end
    end
  end

  // Grant is issued in the arbitration cycle itself; gated by resetn so reset shows no grant.
  assign grant_go = (state == IDLE) && resetn && bus.drw_done && found;

  always_comb begin
    bus.req_grant = '0;
    if (grant_go) bus.req_grant[winner] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      ptr             <= IDX_W'(NUM_REQ - 1);
      owner           <= '0;
      watchdog        <= '0;
      bus.req_done    <= '0;
      bus.drw_data_x  <= '0;
      bus.drw_data_y  <= '0;
      bus.drw_color   <= '0;
      bus.drw_load_x  <= 1'b0;
      bus.drw_plot    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.drw_load_x <= 1'b0;
      bus.drw_plot   <= 1'b0;
      bus.req_done   <= '0;
      case (state)
        IDLE: begin
          if (grant_go) begin
            state          <= ISSUE_X;
            ptr            <= winner;
            owner          <= winner;
            bus.drw_data_x <= cap_x;
            bus.drw_data_y <= cap_y;
            bus.drw_color  <= cap_color;
            bus.drw_load_x <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        ISSUE_X: begin
          state        <= ISSUE_Y;
          bus.drw_plot <= 1'b1;
        end
        ISSUE_Y: begin
          state    <= WAIT_DONE;
          watchdog <= '0;
        end
        WAIT_DONE: begin
          // The drawer left LOADX during ISSUE_X, so a high drw_done here is a genuine completion.
          if (bus.drw_done) begin
            state               <= FINISH;
            bus.req_done[owner] <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
            if (watchdog == TO_W'(TIMEOUT - 1)) begin
              bus.timeout_err     <= 1'b1;
              state               <= FINISH;
              bus.req_done[owner] <= 1'b1;
            end
          end
        end
        FINISH: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb/tb_tile_draw_scheduler.sv - randomized self-checking bench for tile_draw_scheduler
module tb_tile_draw_scheduler;
  localparam int N       = 3;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tile_draw_scheduler_if #(.NUM_REQ(N)) bus();

  tile_draw_scheduler #(.NUM_REQ(N), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clock (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int px[N];
  int py[N];
  int pc[N];
  int ptr_m;

  // Drawer model: idle (done high) until load_x, then done returns lat cycles after plot.
  logic done_r;
  int   cnt;
  bit   hang = 1'b0;
  bit   kick = 1'b0;
  bit   force_low = 1'b0;
  int   lat = 48;
  assign bus.drw_done = done_r & ~force_low;

  always @(posedge clk) begin
    if (!resetn) begin
      done_r <= 1'b1;
      cnt    <= 0;
    end else if (kick) begin
      done_r <= 1'b1;
      cnt    <= 0;
    end else if (bus.drw_load_x) begin
      done_r <= 1'b0;
    end else if (bus.drw_plot) begin
      if (!hang) cnt <= lat;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) done_r <= 1'b1;
    end
  end

  bit multi_hot = 1'b0;
  always @(negedge clk)
    if ($countones(bus.req_grant) > 1 || $countones(bus.req_done) > 1) multi_hot <= 1'b1;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    ptr_m = N - 1;
  endtask

  task automatic load_payloads();
    for (int i = 0; i < N; i++) begin
      px[i] = $urandom_range(0, 511);
      py[i] = $urandom_range(0, 255);
      pc[i] = $urandom_range(0, 7);
      bus.req_x[9*i +: 9]     = 9'(px[i]);
      bus.req_y[8*i +: 8]     = 8'(py[i]);
      bus.req_color[3*i +: 3] = 3'(pc[i]);
    end
  endtask

  task automatic wait_grant(input int max, output int idx, output bit ok);
    idx = -1;
    ok  = 1'b0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (bus.req_grant != 0) begin
        for (int j = 0; j < N; j++) if (bus.req_grant[j]) idx = j;
        ok = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic wait_done(input int max, output logic [N-1:0] vec, output bit ok);
    vec = '0;
    ok  = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.req_done != 0) begin
        vec = bus.req_done;
        ok  = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_color = '0;
    resetn = 1'b0;
    step();
    step();
    checks++;
    if (bus.req_grant !== '0 || bus.req_done !== '0) begin
      errors++; $display("FAIL reset_handshake: grant=%b done=%b expected 0", bus.req_grant, bus.req_done);
    end
    checks++;
    if ({bus.drw_load_x, bus.drw_plot, bus.busy, bus.timeout_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: load_x/plot/busy/err=%b expected 0000",
                         {bus.drw_load_x, bus.drw_plot, bus.busy, bus.timeout_err});
    end
    checks++;
    if ({bus.drw_data_x, bus.drw_data_y, bus.drw_color} !== 20'b0) begin
      errors++; $display("FAIL reset_data: x=%0d y=%0d c=%0d expected 0", bus.drw_data_x, bus.drw_data_y, bus.drw_color);
    end
    resetn = 1'b1;
    ptr_m = N - 1;
  endtask

  task automatic test_single();
    int seen;
    do_reset();
    bus.req_x[8:0] = 9'd40;
    bus.req_y[7:0] = 8'd20;
    bus.req_color[2:0] = 3'b101;
    bus.req_valid = 3'b001;
    #1;
    checks++;
    if (bus.req_grant !== 3'b001) begin
      errors++; $display("FAIL single_grant: got %b expected 001", bus.req_grant);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.drw_load_x !== 1'b1 || bus.drw_plot !== 1'b0 || bus.drw_data_x !== 9'd40) begin
      errors++; $display("FAIL single_load_x: load_x=%b plot=%b x=%0d expected 1 0 40",
                         bus.drw_load_x, bus.drw_plot, bus.drw_data_x);
    end
    step();
    checks++;
    if (bus.drw_plot !== 1'b1 || bus.drw_load_x !== 1'b0 || bus.drw_data_y !== 8'd20 || bus.drw_color !== 3'd5) begin
      errors++; $display("FAIL single_plot: plot=%b load_x=%b y=%0d c=%0d expected 1 0 20 5",
                         bus.drw_plot, bus.drw_load_x, bus.drw_data_y, bus.drw_color);
    end
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      step();
      if (bus.req_done !== '0) seen = 2;
      else if (bus.drw_done === 1'b1) seen = 1;
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL single_wait: drawer/done sequence code=%0d expected 1", seen);
    end
    step();
    checks++;
    if (bus.req_done !== 3'b001) begin
      errors++; $display("FAIL single_done: got %b expected 001", bus.req_done);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.req_done !== '0 || bus.drw_data_x !== 9'd40) begin
      errors++; $display("FAIL single_after: busy=%b done=%b x=%0d expected 0 000 40", bus.busy, bus.req_done, bus.drw_data_x);
    end
    ptr_m = 0;
  endtask

  task automatic test_rr_all();
    int idx, exp;
    bit ok;
    logic [N-1:0] vec;
    do_reset();
    multi_hot = 1'b0;
    load_payloads();
    bus.req_valid = 3'b111;
    for (int t = 0; t < 4; t++) begin
      exp = rr_pick(ptr_m, bus.req_valid);
      wait_grant(10, idx, ok);
      checks++;
      if (!ok || idx != exp) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", t, idx, exp);
      end
      ptr_m = exp;
      checks++;
      if (bus.drw_data_x !== 9'(px[exp])) begin
        errors++; $display("FAIL rr_data_x[%0d]: got %0d expected %0d", t, bus.drw_data_x, px[exp]);
      end
      wait_done(200, vec, ok);
      checks++;
      if (!ok || vec !== (3'b001 << exp)) begin
        errors++; $display("FAIL rr_done[%0d]: got %b expected %b", t, vec, 3'b001 << exp);
      end
      step();
    end
    bus.req_valid = '0;
    checks++;
    if (multi_hot !== 1'b0) begin
      errors++; $display("FAIL rr_onehot: multi-hot grant/done seen=%b expected 0", multi_hot);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] pats[3];
    int idx, exp;
    bit ok;
    logic [N-1:0] vec;
    pats[0] = 3'b010;
    pats[1] = 3'b011;
    pats[2] = 3'b110;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      bus.req_valid = pats[t];
      exp = rr_pick(ptr_m, pats[t]);
      wait_grant(10, idx, ok);
      bus.req_valid = '0;
      checks++;
      if (!ok || idx != exp) begin
        errors++; $display("FAIL wrap[%0d]: valid=%b got %0d expected %0d", t, pats[t], idx, exp);
      end
      ptr_m = exp;
      wait_done(200, vec, ok);
      step();
    end
  endtask

  task automatic test_done_low();
    int idx;
    bit ok;
    logic [N-1:0] vec;
    do_reset();
    force_low = 1'b1;
    bus.req_valid = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.req_grant !== '0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL done_low_hold[%0d]: grant=%b busy=%b expected 000 0", i, bus.req_grant, bus.busy);
      end
      step();
    end
    force_low = 1'b0;
    wait_grant(2, idx, ok);
    bus.req_valid = '0;
    checks++;
    if (!ok || idx != 0) begin
      errors++; $display("FAIL done_low_release: got %0d expected 0", idx);
    end
    ptr_m = 0;
    wait_done(200, vec, ok);
    step();
  endtask

  task automatic test_timeout();
    int idx, exp, n;
    bit ok;
    logic [N-1:0] vec;
    hang = 1'b1;
    bus.req_valid = 3'b010;
    exp = rr_pick(ptr_m, bus.req_valid);
    wait_grant(10, idx, ok);
    bus.req_valid = '0;
    checks++;
    if (!ok || idx != exp) begin
      errors++; $display("FAIL timeout_grant: got %0d expected %0d", idx, exp);
    end
    ptr_m = exp;
    step();
    n = 0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      step();
      if (bus.timeout_err === 1'b1 || bus.req_done !== '0) break;
      n++;
    end
    checks++;
    if (n != TIMEOUT || bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_cycles: waited %0d err=%b expected %0d 1", n, bus.timeout_err, TIMEOUT);
    end
    checks++;
    if (bus.req_done !== (3'b001 << exp)) begin
      errors++; $display("FAIL timeout_done: got %b expected %b", bus.req_done, 3'b001 << exp);
    end
    step();
    hang = 1'b0;
    kick = 1'b1;
    step();
    kick = 1'b0;
    bus.req_valid = 3'b001;
    exp = rr_pick(ptr_m, bus.req_valid);
    wait_grant(10, idx, ok);
    bus.req_valid = '0;
    checks++;
    if (!ok || idx != exp || bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_recover: got %0d err=%b expected %0d 1", idx, bus.timeout_err, exp);
    end
    ptr_m = exp;
    wait_done(200, vec, ok);
    step();
  endtask

  task automatic test_mid_reset();
    int idx;
    bit ok;
    bit pulse;
    bus.req_valid = 3'b100;
    wait_grant(10, idx, ok);
    bus.req_valid = '0;
    step();
    step();
    step();
    resetn = 1'b0;
    bus.req_valid = 3'b111;
    step();
    checks++;
    if (bus.req_grant !== '0 || bus.req_done !== '0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 ||
        bus.drw_load_x !== 1'b0 || bus.drw_plot !== 1'b0 || bus.drw_data_x !== 9'd0) begin
      errors++; $display("FAIL mid_reset_outputs: grant=%b done=%b busy=%b err=%b x=%0d expected all 0",
                         bus.req_grant, bus.req_done, bus.busy, bus.timeout_err, bus.drw_data_x);
    end
    pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.req_done !== '0) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done: done pulse seen=%b expected 0", pulse);
    end
    resetn = 1'b1;
    ptr_m = N - 1;
    #1;
    checks++;
    if (bus.req_grant !== 3'b001) begin
      errors++; $display("FAIL mid_reset_priority: got %b expected 001", bus.req_grant);
    end
    step();
    bus.req_valid = '0;
    ptr_m = 0;
    begin
      logic [N-1:0] vec;
      wait_done(200, vec, ok);
    end
    step();
  endtask

  task automatic test_random();
    int idx, exp, ex, ey, ec;
    bit ok;
    logic [N-1:0] vec;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      lat = $urandom_range(1, 60);
      load_payloads();
      bus.req_valid = 3'($urandom_range(1, 7));
      exp = rr_pick(ptr_m, bus.req_valid);
      ex = px[exp];
      ey = py[exp];
      ec = pc[exp];
      wait_grant(5, idx, ok);
      checks++;
      if (!ok || idx != exp) begin
        errors++; $display("FAIL random_grant[%0d]: got %0d expected %0d", t, idx, exp);
      end
      ptr_m = exp;
      load_payloads();
      bus.req_valid = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (bus.drw_data_x !== 9'(ex) || bus.drw_data_y !== 8'(ey) || bus.drw_color !== 3'(ec)) begin
        errors++; $display("FAIL random_payload[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                           t, bus.drw_data_x, bus.drw_data_y, bus.drw_color, ex, ey, ec);
      end
      wait_done(200, vec, ok);
      checks++;
      if (!ok || vec !== (3'b001 << exp) || bus.drw_data_x !== 9'(ex)) begin
        errors++; $display("FAIL random_done[%0d]: got %b x=%0d expected %b x=%0d", t, vec, bus.drw_data_x, 3'b001 << exp, ex);
      end
      step();
    end
    bus.req_valid = '0;
    lat = 48;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_wrap();
    test_done_low();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
